cursor_overlay: RTL

- Sits between the PS/2 mouse controller and the VGA output stage.
- Consumes decoded mouse movement packets and accumulates them into a clamped on-screen cursor position.
- Produces the 12-bit RGB pixel value for each scan position supplied by the VGA timing stage: a cursor square drawn over a flat background.
- Position updates are double-buffered and committed only during vertical blank, so no frame shows a torn cursor.

---
 rtl/cursor_overlay.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cursor_overlay.sv
// cursor_overlay: accumulates decoded PS/2 mouse movement into a clamped,
// double-buffered cursor position and renders a coloured cursor square over
// a flat background for the VGA output stage.
// Optional build macro: CURSOR_BLINK_EN (32 frames shown / 32 frames hidden
// unless a button is held). Default build: cursor always drawn.
//
// Handshake: PacketValid is a one-cycle strobe with no back-pressure; the
// block accepts every packet in the cycle it is presented (implicit ready=1).
module cursor_overlay #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          CURSOR_SIZE = 8,
  parameter logic [11:0] BG_RGB      = 12'h000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PacketValid,
  input  logic [8:0]  DeltaX,
  input  logic [8:0]  DeltaY,
  input  logic        OverflowX,
  input  logic        OverflowY,
  input  logic [2:0]  Buttons,
  input  logic        PixelTick,
  input  logic        VideoOn,
  input  logic [9:0]  PixelX,
  input  logic [9:0]  PixelY,
  output logic [9:0]  CursorX,
  output logic [9:0]  CursorY,
  output logic [11:0] RGB,
  output logic        dbg_blank
);

  typedef enum logic {ST_ACTIVE = 1'b0, ST_BLANK = 1'b1} state_t;

  localparam logic signed [11:0] MAX_X    = 12'(H_RES - CURSOR_SIZE);
  localparam logic signed [11:0] MAX_Y    = 12'(V_RES - CURSOR_SIZE);
  localparam logic [9:0]         CENTRE_X = 10'(H_RES / 2);
  localparam logic [9:0]         CENTRE_Y = 10'(V_RES / 2);
  localparam logic [9:0]         V_RES_L  = 10'(V_RES);
  localparam logic [10:0]        SIZE_L   = 11'(CURSOR_SIZE);

  state_t      state_q, state_d;
  logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [2:0]  pend_btn_q, pend_btn_d;
  logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0]  btn_c_q, btn_c_d;
  logic [11:0] rgb_q, rgb_d;
  logic        commit;
  logic signed [11:0] sum_x, sum_y;
  logic        hit, show;

`ifdef CURSOR_BLINK_EN
  logic [5:0]  frame_cnt_q, frame_cnt_d;
`endif

  // Packet accumulation into the pending (back-buffer) position, clamped to screen.
  always_comb begin
    sum_x      = $signed({2'b00, pend_x_q}) + $signed({{3{DeltaX[8]}}, DeltaX});
    sum_y      = $signed({2'b00, pend_y_q}) - $signed({{3{DeltaY[8]}}, DeltaY});
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_btn_d = pend_btn_q;
    if (PacketValid) begin
      if (!OverflowX) begin
        if (sum_x < 12'sd0)      pend_x_d = '0;
        else if (sum_x > MAX_X)  pend_x_d = MAX_X[9:0];
        else                     pend_x_d = sum_x[9:0];
      end
      if (!OverflowY) begin
        // Mouse Y is positive-up, screen Y grows downwards.
        if (sum_y < 12'sd0)      pend_y_d = '0;
        else if (sum_y > MAX_Y)  pend_y_d = MAX_Y[9:0];
        else                     pend_y_d = sum_y[9:0];
      end
      pend_btn_d = Buttons;
    end
  end

  // Frame FSM: one commit pulse on entry to vertical blank.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_ACTIVE: if (PixelTick && (PixelY >= V_RES_L)) begin
        state_d = ST_BLANK;
        commit  = 1'b1;
      end
      ST_BLANK: if (PixelTick && (PixelY == 10'd0)) state_d = ST_ACTIVE;
      default:  state_d = ST_ACTIVE;
    endcase
  end

  // Front-buffer update: commit reads the pre-update pending values.
  always_comb begin
    cur_x_d = commit ? pend_x_q   : cur_x_q;
    cur_y_d = commit ? pend_y_q   : cur_y_q;
    btn_c_d = commit ? pend_btn_q : btn_c_q;
`ifdef CURSOR_BLINK_EN
    frame_cnt_d = commit ? frame_cnt_q + 6'd1 : frame_cnt_q;
`endif
  end

  // Pixel colour for the scan position, registered on PixelTick.
  always_comb begin
    hit = ({1'b0, PixelX} >= {1'b0, cur_x_q}) && ({1'b0, PixelX} < ({1'b0, cur_x_q} + SIZE_L)) &&
          ({1'b0, PixelY} >= {1'b0, cur_y_q}) && ({1'b0, PixelY} < ({1'b0, cur_y_q} + SIZE_L));
`ifdef CURSOR_BLINK_EN
    show = ~frame_cnt_q[5] | (|btn_c_q);
`else
    show = 1'b1;
`endif
    rgb_d = rgb_q;
    if (PixelTick) begin
      if (!VideoOn)            rgb_d = 12'h000;
      else if (hit && show) begin
        if (btn_c_q[0])        rgb_d = 12'hF00;
        else if (btn_c_q[1])   rgb_d = 12'h0F0;
        else if (btn_c_q[2])   rgb_d = 12'h00F;
        else                   rgb_d = 12'hFFF;
      end
      else                     rgb_d = BG_RGB;
    end
  end

  // State registers; reset centres the cursor and restarts the frame FSM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_ACTIVE;
      pend_x_q   <= CENTRE_X;
      pend_y_q   <= CENTRE_Y;
      pend_btn_q <= 3'b000;
      cur_x_q    <= CENTRE_X;
      cur_y_q    <= CENTRE_Y;
      btn_c_q    <= 3'b000;
      rgb_q      <= 12'h000;
    end else begin
      state_q    <= state_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_btn_q <= pend_btn_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      btn_c_q    <= btn_c_d;
      rgb_q      <= rgb_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  // Frame counter for blinking, advanced once per commit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) frame_cnt_q <= 6'd0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`endif

  assign CursorX   = cur_x_q;
  assign CursorY   = cur_y_q;
  assign RGB       = rgb_q;
  assign dbg_blank = (state_q == ST_BLANK);

endmodule
